// File: rtl/rf16b_wr_sched_if.sv
// Requester-side bus of the register-file write-port scheduler.
//
// Handshake (applies to every port i):
//   A write transfers on the rising edge where req_valid[i] and req_ready[i]
//   are both high. While valid is high and ready is low the requester holds
//   its rd/data stable. req_ready[i] is never high while req_valid[i] is low.
//   req_ready is one-hot or zero.
//
// Signals:
//   req_valid [NREQ]        requester i has a write pending
//   req_rd    [2*NREQ]      destination register of requester i, bits [2i+1:2i]
//   req_data  [WIDTH*NREQ]  write data of requester i
//   req_ready [NREQ]        combinational grant to requester i
//
// Modports:
//   master - the writeback sources (drive valid/rd/data, see ready)
//   slave  - the scheduler
interface rf16b_wr_sched_if #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 16
);
  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_rd;
  logic [WIDTH*NREQ-1:0] req_data;
  logic [NREQ-1:0]       req_ready;

  modport master (
    output req_valid,
    output req_rd,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/rf16b_wr_sched.sv
// Write-port scheduler for the 4 x 16-bit register file.
//
// Three writeback sources (0 = load, 1 = ALU, 2 = debug) compete for the
// single write port. One grant per cycle: starved (promoted) ports first,
// lowest index among them, otherwise the lowest valid index. The winning
// write is registered onto rf_rd/rf_data/rf_en. A per-register pending-write
// scoreboard (busy) is set by issue-stage reservations and cleared when the
// file consumes a write, so the issue stage can stall on RAW hazards.
//
// Ports:
//   clk        clock, rising edge
//   rstz       asynchronous active-low reset
//   req        requester bus (slave modport): req_valid/req_rd/req_data in,
//              req_ready out (combinational, one-hot or zero)
//   rf_rd      registered write address to the file
//   rf_data    registered write data to the file
//   rf_en      registered write enable to the file
//   rsv_valid  issue stage reserves a destination register
//   rsv_rd     register being reserved
//   busy       pending-write bit per register R0..R3
//   rsv_err    one-cycle pulse: reservation of an already-busy register
//   dvdd/dgnd  supply pins, pass-through only
module rf16b_wr_sched #(
  parameter int NREQ       = 3,
  parameter int WIDTH      = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic             clk,
  input  logic             rstz,
  rf16b_wr_sched_if.slave  req,
  output logic [1:0]       rf_rd,
  output logic [WIDTH-1:0] rf_data,
  output logic             rf_en,
  input  logic             rsv_valid,
  input  logic [1:0]       rsv_rd,
  output logic [3:0]       busy,
  output logic             rsv_err,
  inout  wire              dvdd,
  inout  wire              dgnd
);

  localparam int         SELW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] CNT_LIM = 4'(STARVE_LIM);

  // Supply pins carry no logic; this keeps them referenced.
  wire unused_supply = dvdd & dgnd;

  logic [3:0]      cnt [NREQ];
  logic [NREQ-1:0] promoted;
  logic [NREQ-1:0] grant;
  logic [SELW-1:0] sel;
  logic            hit;
  logic [3:0]      busy_nxt;

  // A port is promoted only while its counter sits at the limit; the
  // counter is already cleared when valid drops, the valid term just
  // keeps the grant strictly qualified by valid.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      promoted[i] = req.req_valid[i] && (cnt[i] == CNT_LIM);
    end
  end

  // Scan from the top so the lowest qualifying index wins last.
  always_comb begin
    sel   = '0;
    hit   = 1'b0;
    grant = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if ((|promoted) ? promoted[i] : req.req_valid[i]) begin
        sel = SELW'(i);
        hit = 1'b1;
      end
    end
    if (hit && rstz) begin
      grant[sel] = 1'b1;
    end
  end

  assign req.req_ready = grant;

  // Starvation counters: clear on grant or idle, count up while waiting,
  // saturate at the limit.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req.req_valid[i] || grant[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_LIM) begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  // Output register: rd/data hold their last values when idle.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      rf_en   <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
    end else begin
      rf_en <= |grant;
      if (|grant) begin
        rf_rd   <= req.req_rd[2*int'(sel) +: 2];
        rf_data <= req.req_data[WIDTH*int'(sel) +: WIDTH];
      end
    end
  end

  // Scoreboard: the clear is applied first so a same-register reservation
  // in the same cycle overrides it.
  always_comb begin
    busy_nxt = busy;
    if (rf_en) begin
      busy_nxt[rf_rd] = 1'b0;
    end
    if (rsv_valid) begin
      busy_nxt[rsv_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      busy    <= '0;
      rsv_err <= 1'b0;
    end else begin
      busy    <= busy_nxt;
      rsv_err <= rsv_valid && busy[rsv_rd];
    end
  end

endmodule

// File: tb/tb_rf16b_wr_sched.sv
module tb_rf16b_wr_sched;

  localparam int NREQ  = 3;
  localparam int WIDTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstz = 1'b0;
  always #5 clk = ~clk;

  rf16b_wr_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  logic [1:0]       rf_rd;
  logic [WIDTH-1:0] rf_data;
  logic             rf_en;
  logic             rsv_valid;
  logic [1:0]       rsv_rd;
  logic [3:0]       busy;
  logic             rsv_err;
  wire              dvdd = 1'b1;
  wire              dgnd = 1'b0;

  rf16b_wr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .STARVE_LIM(4)) dut (
    .clk       (clk),
    .rstz      (rstz),
    .req       (bus),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .rf_en     (rf_en),
    .rsv_valid (rsv_valid),
    .rsv_rd    (rsv_rd),
    .busy      (busy),
    .rsv_err   (rsv_err),
    .dvdd      (dvdd),
    .dgnd      (dgnd)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [NREQ-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // there as well, far from the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] rd, input logic [WIDTH-1:0] d);
    bus.req_valid[i]            = v;
    bus.req_rd[2*i +: 2]        = rd;
    bus.req_data[WIDTH*i +: WIDTH] = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NREQ-1:0] exp_g;
    clear_reqs();
    rsv_valid = 1'b0;
    rsv_rd    = 2'd0;

    // Reset state
    #1;
    tick();
    tick();
    check("rst_rf_en", 32'(rf_en), 32'h0);
    check("rst_rf_rd", 32'(rf_rd), 32'h0);
    check("rst_rf_data", 32'(rf_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsv_err", 32'(rsv_err), 32'h0);
    set_req(0, 1'b1, 2'd1, 16'h1111);
    #1;
    check("rst_ready_low", 32'(bus.req_ready), 32'h0);
    clear_reqs();
    rstz = 1'b1;
    tick();

    // Priority: port 0 before port 1
    set_req(0, 1'b1, 2'd2, 16'h1234);
    set_req(1, 1'b1, 2'd3, 16'hBEEF);
    #1;
    check("pri_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 2'd0, 16'h0);
    check("pri_w0", {15'd0, rf_en, rf_rd, rf_data}, {15'd0, 1'b1, 2'd2, 16'h1234});
    #1;
    check("pri_grant1", 32'(bus.req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 2'd0, 16'h0);
    check("pri_w1", {15'd0, rf_en, rf_rd, rf_data}, {15'd0, 1'b1, 2'd3, 16'hBEEF});
    tick();
    check("pri_idle_en", 32'(rf_en), 32'h0);
    check("pri_busy", 32'(busy), 32'h0);

    // Starvation: port 2 wins on its 5th valid cycle, then port 0 resumes
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    set_req(2, 1'b1, 2'd1, 16'h00AA);
    for (int k = 1; k <= 6; k++) begin
      set_req(0, 1'b1, 2'd0, 16'h1000 + 16'(k));
      #1;
      exp_g = exp_q.pop_front();
      check($sformatf("stv_grant%0d", k), 32'(bus.req_ready), 32'(exp_g));
      tick();
      if (exp_g[2]) begin
        check($sformatf("stv_w%0d", k), {15'd0, rf_en, rf_rd, rf_data}, {15'd0, 1'b1, 2'd1, 16'h00AA});
        set_req(2, 1'b0, 2'd0, 16'h0);
      end else begin
        check($sformatf("stv_w%0d", k), {15'd0, rf_en, rf_rd, rf_data}, {15'd0, 1'b1, 2'd0, 16'h1000 + 16'(k)});
      end
    end
    clear_reqs();
    tick();

    // Scoreboard: reserve R1, port 1 writes R1
    rsv_valid = 1'b1;
    rsv_rd    = 2'd1;
    tick();
    rsv_valid = 1'b0;
    check("sb_busy_set", 32'(busy), 32'h2);
    check("sb_no_err", 32'(rsv_err), 32'h0);
    set_req(1, 1'b1, 2'd1, 16'h5555);
    #1;
    check("sb_grant1", 32'(bus.req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 2'd0, 16'h0);
    check("sb_busy_hold", 32'(busy), 32'h2);
    tick();
    check("sb_busy_clr", 32'(busy), 32'h0);

    // Collision: reserve R2 in the cycle rf_en=1 writes R2
    set_req(0, 1'b1, 2'd2, 16'h7777);
    tick();
    set_req(0, 1'b0, 2'd0, 16'h0);
    check("col_w", {15'd0, rf_en, rf_rd, rf_data}, {15'd0, 1'b1, 2'd2, 16'h7777});
    rsv_valid = 1'b1;
    rsv_rd    = 2'd2;
    tick();
    rsv_valid = 1'b0;
    check("col_busy", 32'(busy), 32'h4);
    check("col_no_err", 32'(rsv_err), 32'h0);
    rsv_valid = 1'b1;
    rsv_rd    = 2'd2;
    tick();
    rsv_valid = 1'b0;
    check("col_err_pulse", 32'(rsv_err), 32'h1);
    check("col_busy_kept", 32'(busy), 32'h4);
    tick();
    check("col_err_drop", 32'(rsv_err), 32'h0);

    // Idle: outputs hold
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("idle%0d", k), {15'd0, rf_en, rf_rd, rf_data}, {15'd0, 1'b0, 2'd2, 16'h7777});
    end

    // Reset mid-stream with all ports valid
    set_req(0, 1'b1, 2'd3, 16'h0C0C);
    set_req(1, 1'b1, 2'd0, 16'hAAAA);
    set_req(2, 1'b1, 2'd1, 16'hBBBB);
    #1;
    check("mid_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    check("mid_w", 32'(rf_en), 32'h1);
    rstz = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    check("mid_rst_en", 32'(rf_en), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    tick();
    tick();
    rstz = 1'b1;
    #1;
    check("rel_no_pulse", 32'(rf_en), 32'h0);
    check("rel_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    check("rel_w", {15'd0, rf_en, rf_rd, rf_data}, {15'd0, 1'b1, 2'd3, 16'h0C0C});
    clear_reqs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf16b_wr_sched.md
# rf16b_wr_sched

Write-port scheduler for the 4 x 16-bit register file. Three writeback sources (load unit, ALU, debug port) compete for the file's single write port. The block grants one per cycle with fixed priority plus starvation promotion, and drives registered `rd`/`data`/`en` to the file. It also keeps a per-register pending-write scoreboard that the issue stage uses to stall on RAW hazards.

## Interface
- `NREQ`, 3: number of requesters. Index 0 = load, 1 = ALU, 2 = debug.
- `WIDTH`, 16: data width.
- `STARVE_LIM`, 4: wait cycles (1..15) after which a requester is promoted.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstz`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NREQ  requester i has a write pending.
- `req_rd`  in  2*NREQ  destination register of requester i; bits [2i+1:2i].
- `req_data`  in  WIDTH*NREQ  write data of requester i.
- `req_ready`  out  NREQ  grant to requester i; one-hot or zero, combinational.
- `rf_rd`  out  2  register-file write address (registered).
- `rf_data`  out  WIDTH  register-file write data (registered).
- `rf_en`  out  1  register-file write enable (registered).
- `rsv_valid`  in  1  issue stage reserves a destination.
- `rsv_rd`  in  2  register being reserved.
- `busy`  out  4  pending-write bit per register R0..R3.
- `rsv_err`  out  1  one-cycle pulse: reservation made on an already-busy register.
- `dvdd`, `dgnd`  inout  1  supply pins; pass-through only.

## Operation
- Handshake:
  - A transfer on port i occurs in a cycle where `req_valid[i]` and `req_ready[i]` are both high.
  - The requester must hold `rd`/`data` stable while valid and not ready.
  - `req_ready` never asserts for a port whose valid is low.
- Arbitration, one grant per cycle:
  - Promoted requesters win first, lowest index among promoted.
  - Otherwise the lowest valid index wins.
- Starvation counter per port (4 bits):
  - Clears when the port is granted or `req_valid[i]` is low.
  - Increments when the port is valid and not granted, saturating at `STARVE_LIM`.
  - The port is promoted while its counter equals `STARVE_LIM`.
- Output register:
  - On a transfer: `rf_en`=1, `rf_rd`=`req_rd[i]`, `rf_data`=`req_data[i]`.
  - With no transfer: `rf_en`=0, and `rf_rd`/`rf_data` hold their last values.
- Scoreboard:
  - `rsv_valid` sets `busy[rsv_rd]`.
  - A cycle with `rf_en`=1 clears `busy[rf_rd]`.
  - If set and clear hit the same register in the same cycle, set wins and `busy` stays 1.
  - Reserving a register whose bit is already 1 pulses `rsv_err` in the next cycle; `busy` stays 1.
  - A write to a non-busy register is legal and leaves `busy` unchanged.
- Reset (asynchronous, `rstz`=0):
  - `rf_en`=0, `rf_rd`=0, `rf_data`=0, `busy`=0, `rsv_err`=0, all counters 0.
  - `req_ready`=0 while `rstz` is low.
  - Reset mid-transfer discards the registered write; no `rf_en` pulse follows the release of reset.

## Timing
- Grant is combinational, in the same cycle as valid.
- `rf_en` rises one cycle after the transfer edge; the register file captures the data on the next edge. Total latency from handshake to data visible on `opA`/`opB` is 2 edges.
- `busy` updates one edge after `rsv_valid`, and clears on the edge where `rf_en`=1 is consumed. The same edge writes the file, so a reader stalled on `busy` sees the new value in the first cycle `busy` is low.
- Worst-case wait for a continuously valid port: `STARVE_LIM` cycles, plus up to `NREQ`-1 cycles if several ports are promoted.
- Throughput: one write per cycle, back-to-back.

## Test plan
- Reset: assert `rstz`=0 mid-stream with `req_valid`=3'b111 → `req_ready`=0, `rf_en`=0, `busy`=0. After release, the first grant goes to port 0.
- Priority: ports 0 and 1 valid with rd=2/0x1234 and rd=3/0xBEEF → cycle 1 grants port 0, then `rf_en`=1, `rf_rd`=2, `rf_data`=0x1234. Cycle 2 grants port 1 and writes 0xBEEF to R3.
- Starvation: port 0 valid every cycle with changing data, port 2 held valid with rd=1/0x00AA, `STARVE_LIM`=4 → port 2 is granted exactly on its 5th valid cycle, then port 0 resumes.
- Scoreboard: reserve R1, then port 1 writes R1 → `busy`=4'b0010 after the reserve edge, and `busy`=0 on the edge after the transfer.
- Collision: `rsv_valid` for R2 in the same cycle that `rf_en`=1 with `rf_rd`=2 → `busy[2]` stays 1. A second reserve of R2 → `rsv_err` is high for exactly one cycle.
- Idle: no valids for 10 cycles → `rf_en`=0 throughout, and `rf_rd`/`rf_data` hold their last values.
